// File: rtl/serial_pkg.sv
// Shared types and widths for the serial capture path.
// Used by the word transmitter and its downstream shift register.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } tx_state_t;

    localparam int SER_WORD_W = 4;

endpackage

// File: rtl/serial_word_tx_if.sv
// Valid/ready word handshake into the serial transmitter.
// The master is the word source; the slave is the transmitter.
interface serial_word_tx_if
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WORD_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, one bit per clock on ser_data.
// Optional idle gap after each word; back-to-back words when the gap is 0.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = SER_WORD_W,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    serial_word_tx_if.slave   in_if,
    output logic              ser_data,
    output logic              ser_en,
    output logic              frame_done,
    output logic              busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    tx_state_t        state;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             accept;
    logic             last_bit;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign last_bit = (state == SHIFT) && (bit_cnt == '0);

    assign in_if.in_ready = !reset &&
        ((state == IDLE) || (last_bit && (GAP_CYCLES == 0)));

    assign accept = in_if.in_valid && in_if.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ser_data   <= 1'b0;
            ser_en     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ser_data   <= 1'b0;
            ser_en     <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        word     <= in_if.in_data;
                        bit_cnt  <= LAST_IDX;
                        ser_data <= head(in_if.in_data);
                        ser_en   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        // word holds the bit on the wire at its head
                        word       <= advance(word);
                        ser_data   <= head(advance(word));
                        ser_en     <= 1'b1;
                        frame_done <= (bit_cnt == CW'(1));
                        bit_cnt    <= bit_cnt - 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else if (accept) begin
                        word     <= in_if.in_data;
                        bit_cnt  <= LAST_IDX;
                        ser_data <= head(in_if.in_data);
                        ser_en   <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: single word, back-to-back, gap,
// reset mid-word, backpressure and LSB-first order.
module tb_serial_word_tx;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    serial_word_tx_if #(.WIDTH(4)) if0 ();
    serial_word_tx_if #(.WIDTH(4)) if1 ();
    serial_word_tx_if #(.WIDTH(4)) if2 ();

    logic d0, en0, fd0, bz0;
    logic d1, en1, fd1, bz1;
    logic d2, en2, fd2, bz2;
    logic [3:0] sr0;

    serial_word_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .in_if(if0.slave),
        .ser_data(d0), .ser_en(en0), .frame_done(fd0), .busy(bz0)
    );

    serial_word_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .in_if(if1.slave),
        .ser_data(d1), .ser_en(en1), .frame_done(fd1), .busy(bz1)
    );

    serial_word_tx #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .in_if(if2.slave),
        .ser_data(d2), .ser_en(en2), .frame_done(fd2), .busy(bz2)
    );

    // downstream 4-bit serial-in shift register
    always @(posedge clk or posedge reset) begin
        if (reset) sr0 <= 4'h0;
        else if (en0) sr0 <= {sr0[2:0], d0};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word0(input string tag, input logic [3:0] w);
        if0.in_valid = 1'b1;
        if0.in_data  = w;
        chk({tag, "_rdy"}, 32'(if0.in_ready), 1);
        tick();
        if0.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_en"}, 32'(en0), 1);
            chk({tag, "_bit"}, 32'(d0), 32'(w[3-k]));
            chk({tag, "_fd"}, 32'(fd0), 32'(k == 3));
            tick();
        end
        chk({tag, "_sr"}, 32'(sr0), 32'(w));
        chk({tag, "_en_off"}, 32'(en0), 0);
        chk({tag, "_busy_off"}, 32'(bz0), 0);
    endtask

    initial begin
        logic [7:0] exp8;
        logic [3:0] w;
        int         cnt;

        reset = 1'b1;
        if0.in_valid = 1'b0; if0.in_data = 4'h0;
        if1.in_valid = 1'b0; if1.in_data = 4'h0;
        if2.in_valid = 1'b0; if2.in_data = 4'h0;
        #1;
        chk("rst_rdy", 32'({if0.in_ready, if1.in_ready, if2.in_ready}), 0);
        chk("rst_out", 32'({d0, en0, fd0, bz0}), 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", 32'(if0.in_ready), 1);

        // single word
        word0("single", 4'b1011);

        // back-to-back, no gap
        exp8 = 8'hA5;
        if0.in_valid = 1'b1;
        if0.in_data  = 4'hA;
        tick();
        if0.in_data = 4'h5;
        for (int c = 1; c <= 8; c++) begin
            chk("b2b_en", 32'(en0), 1);
            chk("b2b_bit", 32'(d0), 32'(exp8[8-c]));
            chk("b2b_fd", 32'(fd0), 32'(c % 4 == 0));
            chk("b2b_rdy", 32'(if0.in_ready), 32'(c % 4 == 0));
            tick();
            if (c == 4) if0.in_valid = 1'b0;
        end
        chk("b2b_end", 32'(en0), 0);
        chk("b2b_sr", 32'(sr0), 32'h5);

        // backpressure: 4'h6 waits behind 4'h9
        if0.in_valid = 1'b1;
        if0.in_data  = 4'h9;
        tick();
        if0.in_data = 4'h6;
        for (int c = 1; c <= 4; c++) begin
            chk("bp_rdy", 32'(if0.in_ready), 32'(c == 4));
            tick();
        end
        if0.in_valid = 1'b0;
        w = 4'h6;
        for (int k = 0; k < 4; k++) begin
            chk("bp_bit", 32'({en0, d0}), 32'({1'b1, w[3-k]}));
            tick();
        end
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (en0) cnt++;
            tick();
        end
        chk("bp_once", 32'(cnt), 0);
        chk("bp_sr", 32'(sr0), 32'h6);

        // reset mid-word
        if0.in_valid = 1'b1;
        if0.in_data  = 4'hF;
        tick();
        if0.in_valid = 1'b0;
        tick();
        chk("rmw_pre", 32'({en0, d0}), 32'h3);
        reset = 1'b1;
        #1;
        chk("rmw_out", 32'({d0, en0, fd0, bz0}), 0);
        chk("rmw_rdy", 32'(if0.in_ready), 0);
        chk("rmw_sr", 32'(sr0), 0);
        tick();
        chk("rmw_fd", 32'(fd0), 0);
        reset = 1'b0;
        #1;
        word0("rmw_after", 4'h3);

        // gap of 2 cycles between words
        if1.in_valid = 1'b1;
        if1.in_data  = 4'hC;
        tick();
        if1.in_data = 4'h3;
        w = 4'hC;
        for (int k = 0; k < 4; k++) begin
            chk("gap_bit", 32'({en1, d1}), 32'({1'b1, w[3-k]}));
            chk("gap_fd", 32'(fd1), 32'(k == 3));
            chk("gap_rdy_shift", 32'(if1.in_ready), 0);
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            chk("gap_idle", 32'({en1, d1, bz1, if1.in_ready}), 32'h2);
            tick();
        end
        chk("gap_accept", 32'({en1, bz1, if1.in_ready}), 32'h1);
        tick();
        if1.in_valid = 1'b0;
        w = 4'h3;
        for (int k = 0; k < 4; k++) begin
            chk("gap_bit2", 32'({en1, d1}), 32'({1'b1, w[3-k]}));
            tick();
        end
        chk("gap_busy2", 32'({en1, bz1}), 32'h1);

        // LSB first
        if2.in_valid = 1'b1;
        if2.in_data  = 4'b0001;
        tick();
        if2.in_valid = 1'b0;
        w = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            chk("lsb_bit", 32'({en2, d2}), 32'({1'b1, w[k]}));
            chk("lsb_fd", 32'(fd2), 32'(k == 3));
            tick();
        end
        chk("lsb_end", 32'({en2, bz2}), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial transmitter for the serial capture path. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `ser_data`, qualified by `ser_en`. It sits directly upstream of the 4-bit serial-in shift register and drives that register's `data_in`. With the default MSB-first order, word bit i lands in register bit i after WIDTH qualified shifts.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `GAP_CYCLES`, default 0: idle cycles inserted after each word; legal range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a word to send.
- `in_ready`  out  1  transmitter can take a word this cycle.
- `in_data`  in  WIDTH  word to serialize.
- `ser_data`  out  1  current serial bit; 0 whenever `ser_en`=0.
- `ser_en`  out  1  `ser_data` is valid; downstream shifts only when this is 1.
- `frame_done`  out  1  one-cycle pulse, coincident with the last bit of a word.
- `busy`  out  1  high in SHIFT or GAP.

## Operation
- The FSM has three states: IDLE, SHIFT, GAP.
- Handshake:
  - Acceptance happens on a rising edge where `in_valid` && `in_ready`.
  - The upstream source must hold `in_data` stable while `in_valid`=1 and `in_ready`=0.
  - `in_ready` is combinational from state: 1 in IDLE, and 1 in the last SHIFT cycle when GAP_CYCLES=0. It is 0 otherwise, and 0 while `reset` is high.
- IDLE:
  - On acceptance, load `in_data` into the internal word register, set bit_cnt to WIDTH-1, and go to SHIFT.
  - With no acceptance, stay in IDLE.
- SHIFT:
  - Each cycle, drive one registered bit with `ser_en`=1 and decrement bit_cnt.
  - At bit_cnt=0 the current bit is the last one and `frame_done`=1.
  - After the last bit:
    - GAP_CYCLES>0: go to GAP with gap_cnt loaded to GAP_CYCLES-1.
    - GAP_CYCLES=0 and acceptance in that same cycle: load the new word and stay in SHIFT. The result is back-to-back bits with no bubble.
    - GAP_CYCLES=0 and no acceptance: go to IDLE.
- GAP:
  - `ser_en`=0 and `ser_data`=0.
  - gap_cnt decrements each cycle; when it reaches 0, go to IDLE.
- Bit order:
  - MSB_FIRST=1: the word register shifts left and bit WIDTH-1 is sent.
  - MSB_FIRST=0: the word register shifts right and bit 0 is sent.
- Widths: bit_cnt is $clog2(WIDTH) bits and gap_cnt is 4 bits. Neither counter wraps, because each is reloaded before it reaches 0 again.

## Timing
- Reset values, applied immediately on `reset` assertion:
  - state=IDLE; word register = 0; bit_cnt = 0; gap_cnt = 0.
  - `ser_data`=0, `ser_en`=0, `frame_done`=0, `busy`=0, `in_ready`=0.
  - `in_ready` rises in the first cycle after reset is released.
- Latency: for a word accepted at edge N, the first bit is valid in the cycle after edge N. The last bit, with `frame_done`, is valid WIDTH-1 cycles later.
- Throughput:
  - GAP_CYCLES=0: one word every WIDTH cycles.
  - Otherwise: one word every WIDTH+GAP_CYCLES+1 cycles. The extra cycle is the IDLE acceptance cycle.
- Reset mid-word:
  - The word is aborted with no `frame_done` and no partial completion.
  - The downstream register may hold a partial word; it is reset by the same `reset`.
- `in_valid` dropping before acceptance is legal; nothing is sent.
- `ser_en` is never high for more than WIDTH consecutive cycles per accepted word.

## Structure
- Shared package `serial_pkg` holds:
  - the `tx_state_t` typedef (IDLE, SHIFT, GAP);
  - the localparam `SER_WORD_W`=4, the system word width shared with the shift register.
- Single module, with no sub-module; the counters and FSM are small enough to stay inline.
- All outputs except `in_ready` are registered.

## Test plan
- **Single word:** WIDTH=4, MSB_FIRST=1, accept 4'b1011.
  - `ser_data` must be 1,0,1,1 over the 4 `ser_en` cycles, with `frame_done` in the 4th cycle.
  - The downstream shift register must then read 4'b1011.
- **Back-to-back, GAP_CYCLES=0:** `in_valid` held high with 4'hA then 4'h5.
  - Required: 8 consecutive `ser_en` cycles carrying 1,0,1,0,0,1,0,1.
  - `frame_done` in cycles 4 and 8; `in_ready` high in cycles 4 and 8.
- **Gap, GAP_CYCLES=2:** two words sent back to back.
  - After the first word: 2 cycles of `ser_en`=0 with `busy`=1, then 1 IDLE cycle with `in_ready`=1.
  - The second word's first bit follows that IDLE cycle.
- **Reset mid-word:** assert reset after 2 bits of 4'hF.
  - All outputs must be 0 immediately, with no `frame_done`.
  - After release, 4'h3 must be sent as 0,0,1,1 in full.
- **Backpressure:** hold `in_valid`=1 with 4'h6 during a busy word.
  - The new word must be accepted only on an `in_ready`=1 edge and sent exactly once.
- **LSB-first:** MSB_FIRST=0, accept 4'b0001.
  - `ser_data` must be 1,0,0,0.
